// File: rtl/mac_out_accumulator_pkg.sv
// Shared types and constants for the MAC output accumulator.
// The pipeline depth lives here so it stays in lockstep with the multiply/adder-tree MAC.
package mac_out_accumulator_pkg;

  localparam int ACCUMULATOR_WIDTH = 32;
  localparam int MAC_LATENCY       = 3;

  typedef logic signed [ACCUMULATOR_WIDTH-1:0] acc_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } issue_tag_t;

  function automatic acc_t relu(input acc_t x);
    return x[ACCUMULATOR_WIDTH-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/mac_out_accumulator_if.sv
// Issue, MAC result and output handshake bundle of the MAC output accumulator.
// The master modport is the scheduler/consumer side; the slave modport is the accumulator.
interface mac_out_accumulator_if;
  import mac_out_accumulator_pkg::*;

  logic issue_valid_in;
  logic issue_first_in;
  logic issue_last_in;
  logic issue_ready_out;
  acc_t mac_in;
  acc_t out_data;
  logic out_valid;
  logic out_ready;

  modport master (
    output issue_valid_in, issue_first_in, issue_last_in, mac_in, out_ready,
    input  issue_ready_out, out_data, out_valid
  );

  modport slave (
    input  issue_valid_in, issue_first_in, issue_last_in, mac_in, out_ready,
    output issue_ready_out, out_data, out_valid
  );

endinterface

// File: rtl/mac_out_accumulator_result_fifo.sv
// Synchronous first-word-fall-through result buffer with an occupancy count.
// When empty, out_data keeps presenting the most recently popped word.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hold_q;
  logic             full;
  logic             pop;
  logic             push_en;

  assign full      = (cnt_q == CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && pop_ready;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign push_en   = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : hold_q;
  assign count     = cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr];
      end
      case ({push_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mac_out_accumulator.sv
// Accumulates aligned MAC partial sums into results and buffers them with credit backpressure.
// Optional build macro MAC_OUT_RELU_EN clamps negative results to zero on push.
module mac_out_accumulator
  import mac_out_accumulator_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  arst_n_in,
  mac_out_accumulator_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = CW + 2;

  issue_tag_t    tags [MAC_LATENCY];
  issue_tag_t    aligned;
  acc_t          acc_q;
  acc_t          acc_sum;
  acc_t          push_val;
  logic          accept;
  logic          push;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] lasts_in_flight;
  logic [PW-1:0] pending;
  logic          ready;

  assign accept  = bus.issue_valid_in && ready;
  assign aligned = tags[MAC_LATENCY-1];
  assign push    = aligned.v && aligned.last;

  // Bubbles carry no first/last so they never consume a credit.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < MAC_LATENCY; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= '{v: accept, first: accept && bus.issue_first_in, last: accept && bus.issue_last_in};
      for (int i = 1; i < MAC_LATENCY; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  always_comb begin
    acc_sum = aligned.first ? bus.mac_in : acc_q + bus.mac_in;
`ifdef MAC_OUT_RELU_EN
    push_val = relu(acc_sum);
`else
    push_val = acc_sum;
`endif
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      acc_q <= '0;
    end else if (aligned.v) begin
      acc_q <= aligned.last ? '0 : acc_sum;
    end
  end

  // Credits cover both buffered results and results still inside the MAC pipeline.
  always_comb begin
    lasts_in_flight = '0;
    for (int i = 0; i < MAC_LATENCY; i++) begin
      lasts_in_flight = lasts_in_flight + PW'(tags[i].last);
    end
    pending = PW'(fifo_count) + lasts_in_flight;
    ready   = (pending < PW'(FIFO_DEPTH));
  end

  assign bus.issue_ready_out = ready;

  result_fifo #(
    .WIDTH (ACCUMULATOR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .arst_n    (arst_n_in),
    .push      (push),
    .push_data (push_val),
    .pop_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mac_out_accumulator.sv
// Directed self-checking bench for mac_out_accumulator with a 3-stage MAC result model.
module tb_mac_out_accumulator;
  import mac_out_accumulator_pkg::*;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  mac_out_accumulator_if bus();

  mac_out_accumulator #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .arst_n_in (arst_n),
    .bus       (bus)
  );

  // Stand-in for the MAC: the operand value applied with an issue reappears 3 cycles later.
  acc_t issue_mac = '0;
  acc_t p1 = '0, p2 = '0, p3 = '0;
  always @(posedge clk) begin
    p1 <= issue_mac;
    p2 <= p1;
    p3 <= p2;
  end
  assign bus.mac_in = p3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid_in = 1'b0;
    bus.issue_first_in = 1'b0;
    bus.issue_last_in  = 1'b0;
    issue_mac          = acc_t'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      idle();
      tick();
    end
  endtask

  task automatic issue(input bit f, input bit l, input acc_t v, input string tag);
    bus.issue_valid_in = 1'b1;
    bus.issue_first_in = f;
    bus.issue_last_in  = l;
    issue_mac          = v;
    check(32'(bus.issue_ready_out), 32'd1, tag);
    tick();
    idle();
  endtask

  task automatic wait_out(input acc_t exp, input string tag);
    int i;
    i = 0;
    while (!bus.out_valid && i < 12) begin
      tick();
      i++;
    end
    check(32'(bus.out_valid), 32'd1, {tag, "_valid"});
    check(bus.out_data, exp, tag);
    tick();
  endtask

  acc_t rec [8];
  int   got;
  bit   accepted;
  acc_t exp_wrap;

  initial begin
    arst_n        = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    #12;
    check(32'(bus.issue_ready_out), 32'd1, "rst_ready");
    check(32'(bus.out_valid), 32'd0, "rst_valid");
    check(bus.out_data, 32'd0, "rst_data");
    tick();
    arst_n = 1'b1;
    tick();

    // Single 4-beat group, exact latency
    issue(1'b1, 1'b0, 32'sd10, "t1_iss0");
    issue(1'b0, 1'b0, -32'sd3, "t1_iss1");
    issue(1'b0, 1'b0, 32'sd7, "t1_iss2");
    issue(1'b0, 1'b1, 32'sd100, "t1_iss3");
    check(32'(bus.out_valid), 32'd0, "t1_lat1");
    tick();
    check(32'(bus.out_valid), 32'd0, "t1_lat2");
    tick();
    check(32'(bus.out_valid), 32'd0, "t1_lat3");
    tick();
    check(32'(bus.out_valid), 32'd1, "t1_lat4_valid");
    check(bus.out_data, 32'd114, "t1_sum");
    tick();
    check(32'(bus.out_valid), 32'd0, "t1_popped");
    check(bus.out_data, 32'd114, "t1_hold");

    // Back-to-back single-beat groups
    issue(1'b1, 1'b1, 32'sd5, "t2_iss0");
    issue(1'b1, 1'b1, 32'sd6, "t2_iss1");
    issue(1'b1, 1'b1, 32'sd7, "t2_iss2");
    check(32'(bus.out_valid), 32'd0, "t2_pre");
    tick();
    check(bus.out_data, 32'd5, "t2_out0");
    tick();
    check(bus.out_data, 32'd6, "t2_out1");
    check(32'(bus.out_valid), 32'd1, "t2_valid1");
    tick();
    check(bus.out_data, 32'd7, "t2_out2");
    tick();
    check(32'(bus.out_valid), 32'd0, "t2_empty");

    // Backpressure and credit stall
    bus.out_ready = 1'b0;
    issue(1'b1, 1'b1, 32'sd11, "t3_iss0");
    issue(1'b1, 1'b1, 32'sd12, "t3_iss1");
    issue(1'b1, 1'b1, 32'sd13, "t3_iss2");
    issue(1'b1, 1'b1, 32'sd14, "t3_iss3");
    check(32'(bus.issue_ready_out), 32'd0, "t3_credit_out");
    bus.issue_valid_in = 1'b1;
    bus.issue_first_in = 1'b1;
    bus.issue_last_in  = 1'b1;
    issue_mac          = 32'sd15;
    repeat (6) tick();
    check(32'(bus.issue_ready_out), 32'd0, "t3_stalled");
    check(32'(bus.out_valid), 32'd1, "t3_full_valid");
    check(bus.out_data, 32'd11, "t3_head_stable");
    bus.out_ready = 1'b1;
    got      = 0;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid && bus.out_ready && got < 8) begin
        rec[got] = bus.out_data;
        got++;
      end
      if (bus.issue_valid_in && bus.issue_ready_out) accepted = 1'b1;
      tick();
      if (accepted) idle();
    end
    check(32'(accepted), 32'd1, "t3_fifth_accepted");
    check(32'(got), 32'd5, "t3_drain_count");
    check(rec[0], 32'd11, "t3_drain0");
    check(rec[1], 32'd12, "t3_drain1");
    check(rec[2], 32'd13, "t3_drain2");
    check(rec[3], 32'd14, "t3_drain3");
    check(rec[4], 32'd15, "t3_drain4");

    // Two's-complement wrap
`ifdef MAC_OUT_RELU_EN
    exp_wrap = '0;
`else
    exp_wrap = acc_t'(32'h8000_0000);
`endif
    issue(1'b1, 1'b0, acc_t'(32'h7FFF_FFFF), "t4_iss0");
    issue(1'b0, 1'b1, 32'sd1, "t4_iss1");
    wait_out(exp_wrap, "t4_wrap");

    // Bubbles inside a group
    issue(1'b1, 1'b0, 32'sd1, "t5_iss0");
    idle_cycles(2);
    issue(1'b0, 1'b0, 32'sd2, "t5_iss1");
    idle_cycles(2);
    issue(1'b0, 1'b1, 32'sd3, "t5_iss2");
    wait_out(32'sd6, "t5_bubbles");

    // Reset with one buffered result and two beats in flight
    bus.out_ready = 1'b0;
    issue(1'b1, 1'b1, 32'sd42, "t6_iss0");
    idle_cycles(2);
    issue(1'b1, 1'b0, 32'sd50, "t6_iss1");
    issue(1'b0, 1'b1, 32'sd60, "t6_iss2");
    check(32'(bus.out_valid), 32'd1, "t6_pre_valid");
    arst_n = 1'b0;
    #1;
    check(32'(bus.out_valid), 32'd0, "t6_rst_valid");
    check(32'(bus.issue_ready_out), 32'd1, "t6_rst_ready");
    check(bus.out_data, 32'd0, "t6_rst_data");
    tick();
    tick();
    arst_n        = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check(32'(bus.out_valid), 32'd0, "t6_no_stale");
      tick();
    end
    issue(1'b1, 1'b0, 32'sd9, "t6_iss3");
    issue(1'b0, 1'b1, 32'sd1, "t6_iss4");
    wait_out(32'sd10, "t6_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
